// File: rtl/dp_ram_param_if.sv
// Request/response bundle for dp_ram_param; parity_err exists only when
// DP_RAM_PARITY_EN is defined.
interface dp_ram_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  write;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [NB-1:0]         wr_be;
  logic                  read;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  ready;
  logic                  collision;
`ifdef DP_RAM_PARITY_EN
  logic [NB-1:0]         parity_err;

  modport master (
    output write, wr_address, data_in, wr_be, read, rd_address,
    input  data_out, rd_valid, ready, collision, parity_err
  );
  modport slave (
    input  write, wr_address, data_in, wr_be, read, rd_address,
    output data_out, rd_valid, ready, collision, parity_err
  );
`else
  modport master (
    output write, wr_address, data_in, wr_be, read, rd_address,
    input  data_out, rd_valid, ready, collision
  );
  modport slave (
    input  write, wr_address, data_in, wr_be, read, rd_address,
    output data_out, rd_valid, ready, collision
  );
`endif
endinterface

// File: rtl/dp_ram_param.sv
// Simple dual-port byte-enabled RAM, zeroed by a post-reset sweep; optional per-byte parity (DP_RAM_PARITY_EN).
// Latency: RD_LATENCY (1 or 2) cycles from accepted read to rd_valid; full throughput.
// Backpressure: none; requests are dropped while ready=0.
module dp_ram_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int READ_FIRST = 1
) (
  input logic           clock,
  input logic           resetn,
  dp_ram_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  ready_int;
  logic                  clr_we, wr_en, rd_en, col_now;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_old, rd_word;

  logic [RD_LATENCY-1:0] pipe_vld, pipe_col;
  logic [DATA_WIDTH-1:0] pipe_dat [RD_LATENCY];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && (&clr_cnt)) state_nxt = READY;
  end

  always_comb begin
    ready_int = (state == READY);
  end

  // Reset alone never touches the array; only the sweep zeroes it.
  assign clr_we  = resetn && (state == CLEAR);
  assign wr_en   = resetn && ready_int && bus.write;
  assign rd_en   = resetn && ready_int && bus.read;
  assign col_now = wr_en && rd_en && (bus.wr_address == bus.rd_address);

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (bus.wr_be[b]) mem[bus.wr_address][b*8 +: 8] <= bus.data_in[b*8 +: 8];
    end
  end

  assign rd_old = mem[bus.rd_address];

  always_comb begin
    rd_word = rd_old;
    if (READ_FIRST == 0 && col_now)
      for (int b = 0; b < NB; b++)
        if (bus.wr_be[b]) rd_word[b*8 +: 8] = bus.data_in[b*8 +: 8];
  end

  // Stage 0 captures the accepted read; each later stage only reloads on valid so data_out holds.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pipe_vld <= '0;
      pipe_col <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_en;
      pipe_col[0] <= col_now;
      if (rd_en) pipe_dat[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_col[i] <= pipe_col[i-1];
        if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign bus.data_out  = pipe_dat[RD_LATENCY-1];
  assign bus.rd_valid  = pipe_vld[RD_LATENCY-1];
  assign bus.collision = pipe_col[RD_LATENCY-1];
  assign bus.ready     = ready_int;

`ifdef DP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_old, rd_perr;
  logic [NB-1:0] pipe_perr [RD_LATENCY];

  // Even parity: stored bit equals XOR of the byte, so zero bytes carry a zero bit.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      par_mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (bus.wr_be[b]) par_mem[bus.wr_address][b] <= ^bus.data_in[b*8 +: 8];
    end
  end

  assign par_old = par_mem[bus.rd_address];

  always_comb begin
    rd_perr = '0;
    for (int b = 0; b < NB; b++) begin
      rd_perr[b] = (^rd_old[b*8 +: 8]) ^ par_old[b];
      if (READ_FIRST == 0 && col_now && bus.wr_be[b]) rd_perr[b] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_perr[i] <= '0;
    end else begin
      if (rd_en) pipe_perr[0] <= rd_perr;
      for (int i = 1; i < RD_LATENCY; i++)
        if (pipe_vld[i-1]) pipe_perr[i] <= pipe_perr[i-1];
    end
  end

  assign bus.parity_err = pipe_perr[RD_LATENCY-1];
`endif
endmodule

// File: tb/tb_dp_ram_param.sv
// Bench for dp_ram_param: two instances share stimulus, one with latency 1 / read-first,
// one with latency 2 / write-first; a scoreboard queue per instance checks each rd_valid.
module tb_dp_ram_param;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  dp_ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  dp_ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus1.write      = bus0.write;
  assign bus1.wr_address = bus0.wr_address;
  assign bus1.data_in    = bus0.data_in;
  assign bus1.wr_be      = bus0.wr_be;
  assign bus1.read       = bus0.read;
  assign bus1.rd_address = bus0.rd_address;

  dp_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .READ_FIRST(1)) dut0 (
    .clock(clock), .resetn(resetn), .bus(bus0.slave));
  dp_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .READ_FIRST(0)) dut1 (
    .clock(clock), .resetn(resetn), .bus(bus1.slave));

  typedef struct {
    int          due;
    logic [31:0] dat;
    logic        col;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [7:0]  wa;
    logic [31:0] din;
    logic [3:0]  be;
    logic        rd;
    logic [7:0]  ra;
    logic [31:0] exp_rf1;
    logic [31:0] exp_rf0;
    logic        exp_col;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vt[17];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   edge_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic vld, input logic col, input logic [31:0] d);
    exp_t e;
    logic have;
    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (id == 0) ? q0[0] : q1[0];
    if (vld) begin
      if (!have) begin
        check($sformatf("dut%0d unexpected rd_valid", id), 64'(1), 64'(0));
      end else begin
        if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check($sformatf("dut%0d rd latency", id), 64'(edge_n), 64'(e.due));
        check($sformatf("dut%0d data_out", id), 64'(d), 64'(e.dat));
        check($sformatf("dut%0d collision", id), 64'(col), 64'(e.col));
      end
    end else begin
      if (col) check($sformatf("dut%0d collision without rd_valid", id), 64'(1), 64'(0));
      if (have && e.due <= edge_n) begin
        check($sformatf("dut%0d missing rd_valid", id), 64'(0), 64'(1));
        if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edge_n++;
    mon(0, bus0.rd_valid, bus0.collision, bus0.data_out);
    mon(1, bus1.rd_valid, bus1.collision, bus1.data_out);
  endtask

  task automatic drive(input logic wr, input logic [7:0] wa, input logic [31:0] din,
                       input logic [3:0] be, input logic rd, input logic [7:0] ra);
    bus0.write      = wr;
    bus0.wr_address = wa;
    bus0.data_in    = din;
    bus0.wr_be      = be;
    bus0.read       = rd;
    bus0.rd_address = ra;
  endtask

  task automatic push(input logic [31:0] d0, input logic [31:0] d1, input logic c);
    q0.push_back('{edge_n + 1, d0, c});
    q1.push_back('{edge_n + 2, d1, c});
  endtask

  // Drives reads and a write to address 0 throughout the sweep; both must be ignored.
  task automatic wait_ready(input string name);
    int k;
    for (k = 1; k <= 300; k++) begin
      drive(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 1'b1, 8'(k));
      step();
      if (bus0.ready) break;
    end
    check(name, 64'(k), 64'(256));
    check({name, " dut1 ready"}, 64'(bus1.ready), 64'(1));
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
  endtask

  initial begin
    vt[0]  = '{1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'hFF, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h00, 32'h0, 32'h0, 1'b0};
    vt[5]  = '{1'b1, 8'h20, 32'h5, 4'hF, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 8'h20, 32'h9, 4'hF, 1'b1, 8'h20, 32'h5, 32'h9, 1'b1};
    vt[7]  = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h20, 32'h9, 32'h9, 1'b0};
    vt[8]  = '{1'b1, 8'h21, 32'hDEADBEEF, 4'h0, 1'b1, 8'h21, 32'h0, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h21, 32'h0, 32'h0, 1'b0};
    vt[10] = '{1'b1, 8'h01, 32'h01010101, 4'hF, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
    vt[11] = '{1'b1, 8'h02, 32'h02020202, 4'hF, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
    vt[12] = '{1'b1, 8'h03, 32'h03030303, 4'hF, 1'b1, 8'h01, 32'h01010101, 32'h01010101, 1'b0};
    vt[13] = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h02, 32'h02020202, 32'h02020202, 1'b0};
    vt[14] = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h03, 32'h03030303, 32'h03030303, 1'b0};
    vt[15] = '{1'b1, 8'h30, 32'hFFFFFFFF, 4'hA, 1'b1, 8'h30, 32'h0, 32'hFF00FF00, 1'b1};
    vt[16] = '{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h30, 32'hFF00FF00, 32'hFF00FF00, 1'b0};

    resetn = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    step();
    step();
    check("reset ready0", 64'(bus0.ready), 64'(0));
    check("reset ready1", 64'(bus1.ready), 64'(0));
    check("reset rd_valid0", 64'(bus0.rd_valid), 64'(0));
    check("reset rd_valid1", 64'(bus1.rd_valid), 64'(0));
    check("reset collision0", 64'(bus0.collision), 64'(0));
    check("reset collision1", 64'(bus1.collision), 64'(0));
    check("reset data_out0", 64'(bus0.data_out), 64'(0));
    check("reset data_out1", 64'(bus1.data_out), 64'(0));

    resetn = 1'b1;
    wait_ready("init clear length");

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].wr, vt[i].wa, vt[i].din, vt[i].be, vt[i].rd, vt[i].ra);
      if (vt[i].rd) push(vt[i].exp_rf1, vt[i].exp_rf0, vt[i].exp_col);
      step();
    end
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step();
    check("hold data_out0", 64'(bus0.data_out), 64'(32'hFF00FF00));
    check("hold data_out1", 64'(bus1.data_out), 64'(32'hFF00FF00));

    // Read in flight on the latency-2 instance when reset hits: it must never surface.
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10);
    q0.push_back('{edge_n + 1, 32'hAA22CC44, 1'b0});
    step();
    resetn = 1'b0;
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    step();
    check("flush rd_valid1", 64'(bus1.rd_valid), 64'(0));
    check("flush data_out1", 64'(bus1.data_out), 64'(0));
    check("flush ready0", 64'(bus0.ready), 64'(0));
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("mid-clear ready0", 64'(bus0.ready), 64'(0));
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    wait_ready("restart clear length");

    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10);
    push(32'h0, 32'h0, 1'b0);
    step();
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    step();
    step();

`ifdef DP_RAM_PARITY_EN
    drive(1'b1, 8'h40, 32'hAABBCCDD, 4'hF, 1'b0, 8'h00);
    step();
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    step();
    dut0.mem[8'h40][16] = ~dut0.mem[8'h40][16];
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h40);
    push(32'hAABACCDD, 32'hAABBCCDD, 1'b0);
    step();
    drive(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    check("parity_err0", 64'(bus0.parity_err), 64'(4'b0100));
    step();
    check("parity_err1", 64'(bus1.parity_err), 64'(4'b0000));
    step();
`endif

    check("scoreboard0 drained", 64'(q0.size()), 64'(0));
    check("scoreboard1 drained", 64'(q1.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
